rx_conv8x5: RTL and testbench

- Receive-side counterpart of the 40-bit-to-5-byte UART serializer.
- Collects bytes from the UART receiver (one per rx_done_tick), MSB byte first, and assembles them into a 40-bit word.
- Presents the word with a level valid/ack handshake to the downstream flash command/data logic.
- An inter-byte gap timeout discards partial words so the link resynchronises after a dropped byte.

---
 rtl/conv_pkg.sv | 8 +
 rtl/gap_timer.sv | 42 ++++
 rtl/rx_conv8x5.sv | 107 ++++++++++
 tb/tb_rx_conv8x5.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Constants shared by the UART word serializer (transmit) and the word assembler (receive).
// The parameterised blocks take their default values from here.
package conv_pkg;
  localparam int BYTE_W         = 8;
  localparam int NBYTES         = 5;
  localparam int WORD_W         = BYTE_W * NBYTES;
  localparam int TIMEOUT_CYCLES = 200000;
endpackage

// File: rtl/gap_timer.sv
// Inter-byte gap timer. expired is a registered one-cycle strobe that is high in the cycle
// where the count sits at TIMEOUT_CYCLES-1, so the caller can still let a byte arriving then win.
module gap_timer #(
  parameter int TIMEOUT_CYCLES = conv_pkg::TIMEOUT_CYCLES,
  parameter int TO_W           = 18
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic expired
);
  localparam logic [TO_W-1:0] GT_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TO_W-1:0] GT_PRE  = TO_W'(TIMEOUT_CYCLES - 2);

  logic [TO_W-1:0] gt_q, gt_d;
  logic            expired_q, expired_d;

  always_comb begin
    gt_d      = gt_q;
    expired_d = 1'b0;
    if (clear) begin
      gt_d = '0;
    end else if (run) begin
      // Flag one cycle early so the strobe lines up with gt == TIMEOUT_CYCLES-1.
      expired_d = (gt_q == GT_PRE);
      gt_d      = (gt_q == GT_LAST) ? '0 : gt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gt_q      <= '0;
      expired_q <= 1'b0;
    end else begin
      gt_q      <= gt_d;
      expired_q <= expired_d;
    end
  end

  assign expired = expired_q;
endmodule

// File: rtl/rx_conv8x5.sv
// Assembles NBYTES UART bytes (MSB byte first) into a word held in rxout behind a valid/ack level
// handshake. The next word assembles while rxout is held; an inter-byte gap timeout drops partial words.
module rx_conv8x5 #(
  parameter int NBYTES         = conv_pkg::NBYTES,
  parameter int TIMEOUT_CYCLES = conv_pkg::TIMEOUT_CYCLES,
  parameter int TO_W           = 18
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               rx_done_tick,
  input  logic [conv_pkg::BYTE_W-1:0]        din,
  input  logic                               word_ack,
  output logic [conv_pkg::BYTE_W*NBYTES-1:0] rxout,
  output logic                               word_valid,
  output logic                               word_done,
  output logic                               overrun,
  output logic                               timeout_err
);
  localparam int BW    = conv_pkg::BYTE_W;
  localparam int WW    = BW * NBYTES;
  localparam int SRW   = WW - BW;
  localparam int CNT_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(NBYTES - 1);

  // The oldest byte of the shift register is never read, so only NBYTES-1 bytes are stored.
  logic [SRW-1:0]   sr_q, sr_d;
  logic [CNT_W-1:0] bcnt_q, bcnt_d;
  logic [WW-1:0]    rxout_q, rxout_d;
  logic             word_valid_q, word_valid_d;
  logic             word_done_q, word_done_d;
  logic             overrun_q, overrun_d;
  logic             timeout_err_q, timeout_err_d;

  logic          expired, last, timeout, free;
  logic [WW-1:0] word;

  gap_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TO_W          (TO_W)
  ) u_gap_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (rx_done_tick || (bcnt_q == '0)),
    .run    (bcnt_q != '0),
    .expired(expired)
  );

  assign word    = {sr_q, din};
  assign last    = rx_done_tick && (bcnt_q == LAST_BYTE);
  assign timeout = expired && !rx_done_tick;
  assign free    = !word_valid_q || word_ack;

  always_comb begin
    sr_d          = sr_q;
    bcnt_d        = bcnt_q;
    rxout_d       = rxout_q;
    word_valid_d  = word_valid_q;
    word_done_d   = 1'b0;
    overrun_d     = 1'b0;
    timeout_err_d = timeout;

    if (rx_done_tick) begin
      sr_d   = word[SRW-1:0];
      bcnt_d = last ? '0 : bcnt_q + 1'b1;
    end else if (timeout) begin
      sr_d   = '0;
      bcnt_d = '0;
    end

    // A completion with a same-cycle ack replaces the held word rather than clearing valid.
    if (last && free) begin
      rxout_d      = word;
      word_valid_d = 1'b1;
      word_done_d  = 1'b1;
    end else if (last) begin
      overrun_d = 1'b1;
    end else if (word_ack) begin
      word_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr_q          <= '0;
      bcnt_q        <= '0;
      rxout_q       <= '0;
      word_valid_q  <= 1'b0;
      word_done_q   <= 1'b0;
      overrun_q     <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      sr_q          <= sr_d;
      bcnt_q        <= bcnt_d;
      rxout_q       <= rxout_d;
      word_valid_q  <= word_valid_d;
      word_done_q   <= word_done_d;
      overrun_q     <= overrun_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign rxout       = rxout_q;
  assign word_valid  = word_valid_q;
  assign word_done   = word_done_q;
  assign overrun     = overrun_q;
  assign timeout_err = timeout_err_q;
endmodule

// File: tb/tb_rx_conv8x5.sv
// Directed bench for rx_conv8x5 with a 16-cycle gap timeout.
module tb_rx_conv8x5;
  logic        clk = 1'b0;
  logic        reset;
  logic        rx_done_tick;
  logic [7:0]  din;
  logic        word_ack;
  logic [39:0] rxout;
  logic        word_valid, word_done, overrun, timeout_err;

  int errors = 0;
  int checks = 0;

  rx_conv8x5 #(.NBYTES(5), .TIMEOUT_CYCLES(16), .TO_W(5)) dut (
    .clk         (clk),
    .reset       (reset),
    .rx_done_tick(rx_done_tick),
    .din         (din),
    .word_ack    (word_ack),
    .rxout       (rxout),
    .word_valid  (word_valid),
    .word_done   (word_done),
    .overrun     (overrun),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one byte for exactly one clock edge; returns 1ns after that edge.
  task automatic send(input logic [7:0] b, input logic ack);
    rx_done_tick = 1'b1;
    din          = b;
    word_ack     = ack;
    @(posedge clk); #1;
    rx_done_tick = 1'b0;
    word_ack     = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic ack_once();
    word_ack = 1'b1;
    @(posedge clk); #1;
    word_ack = 1'b0;
  endtask

  initial begin
    reset = 1'b1; rx_done_tick = 1'b0; din = 8'h00; word_ack = 1'b0;
    #12;
    check("rst_rxout", rxout, 40'h0);
    check("rst_valid", word_valid, 1'b0);
    check("rst_done", word_done, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    check("rst_timeout", timeout_err, 1'b0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Basic word with 3 idle cycles between bytes
    send(8'hA1, 0); idle(3);
    send(8'hB2, 0); idle(3);
    send(8'hC3, 0); idle(3);
    send(8'hD4, 0);
    check("w1_no_early_done", word_done, 1'b0);
    idle(3);
    send(8'hE5, 0);
    check("w1_rxout", rxout, 40'hA1B2C3D4E5);
    check("w1_valid", word_valid, 1'b1);
    check("w1_done", word_done, 1'b1);
    idle(1);
    check("w1_done_single", word_done, 1'b0);
    check("w1_valid_held", word_valid, 1'b1);
    ack_once();
    check("w1_ack_valid", word_valid, 1'b0);
    check("w1_ack_rxout", rxout, 40'hA1B2C3D4E5);
    ack_once();
    check("ack_idle_ignored", word_valid, 1'b0);

    // Partial word then gap timeout
    send(8'h11, 0); send(8'h22, 0); send(8'h33, 0);
    idle(15);
    check("to_not_early", timeout_err, 1'b0);
    idle(1);
    check("to_pulse", timeout_err, 1'b1);
    check("to_no_done", word_done, 1'b0);
    check("to_valid", word_valid, 1'b0);
    check("to_rxout", rxout, 40'hA1B2C3D4E5);
    idle(1);
    check("to_single", timeout_err, 1'b0);
    send(8'h01, 0); send(8'h02, 0); send(8'h03, 0); send(8'h04, 0); send(8'h05, 0);
    check("after_to_rxout", rxout, 40'h0102030405);
    check("after_to_done", word_done, 1'b1);

    // Overrun: held word not acked while a second word completes
    send(8'h5A, 0); send(8'h5A, 0); send(8'h5A, 0); send(8'h5A, 0); send(8'h5A, 0);
    check("ovr_pulse", overrun, 1'b1);
    check("ovr_no_done", word_done, 1'b0);
    check("ovr_rxout", rxout, 40'h0102030405);
    check("ovr_valid", word_valid, 1'b1);
    idle(1);
    check("ovr_single", overrun, 1'b0);
    ack_once();
    check("ovr_ack_valid", word_valid, 1'b0);
    send(8'h66, 0); send(8'h77, 0); send(8'h88, 0); send(8'h99, 0); send(8'hAA, 0);
    check("w3_rxout", rxout, 40'h66778899AA);
    check("w3_done", word_done, 1'b1);
    check("w3_overrun", overrun, 1'b0);

    // Ack in the same cycle as completion replaces the held word
    send(8'hFF, 0); send(8'hEE, 0); send(8'hDD, 0); send(8'hCC, 0);
    send(8'hBB, 1);
    check("ackc_rxout", rxout, 40'hFFEEDDCCBB);
    check("ackc_valid", word_valid, 1'b1);
    check("ackc_done", word_done, 1'b1);
    check("ackc_overrun", overrun, 1'b0);
    idle(1);
    check("ackc_valid_hold", word_valid, 1'b1);

    // Asynchronous reset mid-word
    send(8'h10, 0); send(8'h20, 0);
    #2 reset = 1'b1;
    #1;
    check("arst_rxout", rxout, 40'h0);
    check("arst_valid", word_valid, 1'b0);
    check("arst_done", word_done, 1'b0);
    #2 reset = 1'b0;
    @(posedge clk); #1;
    send(8'h10, 0); send(8'h20, 0); send(8'h30, 0);
    check("arst_no_stale_done", word_done, 1'b0);
    send(8'h40, 0); send(8'h50, 0);
    check("arst_word_rxout", rxout, 40'h1020304050);
    check("arst_word_done", word_done, 1'b1);
    ack_once();

    // Byte arrives exactly in the timer expiry cycle
    send(8'h12, 0); idle(15);
    send(8'h34, 0);
    check("exp_tick_no_to1", timeout_err, 1'b0);
    idle(15);
    send(8'h56, 0);
    check("exp_tick_no_to2", timeout_err, 1'b0);
    idle(15);
    send(8'h78, 0);
    idle(15);
    send(8'h9A, 0);
    check("exp_tick_rxout", rxout, 40'h123456789A);
    check("exp_tick_done", word_done, 1'b1);
    check("exp_tick_no_to", timeout_err, 1'b0);
    idle(20);
    check("between_words_no_to", timeout_err, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
